// File: rtl/rf_dump_pkg.sv
// Shared constants and FSM encoding for the register-file dump engine.
package rf_dump_pkg;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;
endpackage

// File: rtl/rf_dump.sv
// Debug readout: walks a modulo-NREGS register range through one read port
// and streams (index, value) beats over valid/ready while freezing writeback.
module rf_dump
  import rf_dump_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] first,
  input  logic [AW-1:0] last,
  output logic          busy,
  output logic          hold,
  output logic [AW-1:0] rf_addr,
  input  logic [DW-1:0] rf_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          done
);

  state_t        state, state_nx;
  logic [AW-1:0] idx;
  logic [AW-1:0] last_q;
  logic          at_last;

  assign at_last = (out_addr == last_q);

  always_comb begin
    state_nx  = state;
    rf_addr   = idx;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    busy      = 1'b0;
    hold      = 1'b0;
    unique case (state)
      IDLE: begin
        // First register is read combinationally so it can be captured with start.
        rf_addr = first;
        hold    = start;
        if (start) state_nx = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_last  = at_last;
        busy      = 1'b1;
        hold      = 1'b1;
        if (out_ready && at_last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        busy     = 1'b1;
        hold     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      idx      <= '0;
      last_q   <= '0;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (start) begin
          out_data <= rf_data;
          out_addr <= first;
          last_q   <= last;
          idx      <= AW'((int'(first) + 1) % NREGS);
        end
        SEND: if (out_ready && !at_last) begin
          // Prefetched next register becomes the new beat; read pointer advances.
          out_data <= rf_data;
          out_addr <= idx;
          idx      <= AW'((int'(idx) + 1) % NREGS);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// Bench for rf_dump: register-file + gated writeback model, expected beats
// derived from the range rules on a snapshot taken at start.
module tb_rf_dump;
  import rf_dump_pkg::*;
  localparam int NREGS = DEF_NREGS;
  localparam int AW    = DEF_AW;
  localparam int DW    = DEF_DW;

  logic          clk = 1'b0;
  logic          rst, start, busy, hold, out_valid, out_ready, out_last, done;
  logic [AW-1:0] first, last, rf_addr, out_addr;
  logic [DW-1:0] rf_data, out_data;

  logic [DW-1:0] regs [NREGS];
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;

  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
  beat_t q[$];
  int n_cmp = 0, n_err = 0;

  rf_dump #(.NREGS(NREGS), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .first(first), .last(last),
    .busy(busy), .hold(hold), .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  assign rf_data = (rf_addr == '0) ? '0 : regs[rf_addr];

  // CPU writeback at negedge, suppressed whenever hold is high
  always @(negedge clk) if (wb_en && !hold) regs[wb_addr] = wb_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1,0,1 repeating, 2: random ready
  task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                          input bit restart, input bit wb, input int rst_at);
    int n, beat, cyc;
    bit stall;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    q.delete();
    n = ((int'(l) - int'(f) + NREGS) % NREGS) + 1;
    for (int i = 0; i < n; i++) begin
      beat_t b;
      b.a = AW'((int'(f) + i) % NREGS);
      b.d = (b.a == '0) ? '0 : regs[b.a];
      q.push_back(b);
    end
    start = 1'b1; first = f; last = l; out_ready = 1'b0;
    wb_en = wb; wb_addr = f; wb_data = ~regs[f];
    #1;
    chk("start_hold", hold, 1);
    chk("start_busy", busy, 0);
    chk("start_valid", out_valid, 0);
    @(posedge clk); #1;
    start = restart;
    if (restart) begin first = f + AW'(3); last = f + AW'(5); end
    beat = 0; cyc = 0; stall = 0; pa = '0; pd = '0;
    while (q.size() > 0 && cyc < 400) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[cyc % 6];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (beat == rst_at && out_ready) rst = 1'b1;
      wb_en = wb; wb_addr = AW'($urandom_range(0, NREGS - 1)); wb_data = $urandom;
      #1;
      chk("valid", out_valid, 1);
      chk("hold", hold, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("addr", out_addr, q[0].a);
      chk("data", out_data, q[0].d);
      chk("last", out_last, q.size() == 1);
      if (stall) begin
        chk("stall_addr", out_addr, pa);
        chk("stall_data", out_data, pd);
      end
      stall = !out_ready; pa = out_addr; pd = out_data;
      if (out_ready) begin void'(q.pop_front()); beat++; end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (rst) begin
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_hold", hold, 0);
        rst = 1'b0; wb_en = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          chk("rst_no_done", done, 0);
          chk("rst_no_valid", out_valid, 0);
        end
        return;
      end
    end
    chk("drained", q.size(), 0);
    if (mode == 0) chk("beat_cycles", cyc, n);
    #1;
    chk("done", done, 1);
    chk("done_valid", out_valid, 0);
    chk("done_hold", hold, 1);
    chk("done_busy", busy, 1);
    @(posedge clk); #1;
    wb_en = 1'b0;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
    chk("idle_hold", hold, 0);
    if (restart) begin
      repeat (3) begin
        @(posedge clk); #1;
        chk("no_requeue", out_valid, 0);
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; first = '0; last = '0; out_ready = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    for (int k = 0; k < NREGS; k++) regs[k] = DW'(32'h100 + k);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", out_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_hold", hold, 0);
    start = 1'b1;
    @(posedge clk); #1;
    chk("rst_wins", busy, 0);
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;

    run_dump(5'd0, 5'd31, 0, 0, 0, -1);   // full dump
    run_dump(5'd30, 5'd2, 0, 0, 0, -1);   // wrap range
    run_dump(5'd4, 5'd9, 1, 0, 0, -1);    // backpressure pattern
    run_dump(5'd7, 5'd7, 0, 1, 0, -1);    // single beat, ignored restart
    run_dump(5'd3, 5'd6, 0, 0, 1, -1);    // writeback attempts during dump
    run_dump(5'd0, 5'd31, 0, 0, 0, 10);   // reset mid-dump
    run_dump(5'd0, 5'd31, 2, 0, 1, -1);   // fresh dump after reset

    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NREGS; k++) regs[k] = $urandom;
      run_dump(AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1)),
               2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
